// File: rtl/io_port_pkg.sv
// Shared definitions for the CPU I/O port responder: port map, STATUS bit
// positions and the bus word type.
package io_port_pkg;

  typedef logic [15:0] word_t;

  localparam word_t P_STATUS   = 16'h0000;
  localparam word_t P_GPIO_OUT = 16'h0001;
  localparam word_t P_GPIO_IN  = 16'h0002;
  localparam word_t P_TX       = 16'h0003;
  localparam word_t P_RX       = 16'h0004;
  localparam word_t P_TIMER    = 16'h0005;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_RX_AVAIL  = 2;
  localparam int unsigned ST_TX_OVF    = 3;
  localparam int unsigned ST_RX_CNT_LO = 4;
  localparam int unsigned ST_TX_CNT_LO = 8;

endpackage

// File: rtl/io_port_responder_if.sv
// CPU-side I/O bus: port address, write data, write strobe and read data.
interface io_port_responder_if;
  import io_port_pkg::*;

  word_t base;
  word_t data;
  logic  flag;
  word_t cpu_in;

  modport master (output base, output data, output flag, input cpu_in);
  modport slave  (input base, input data, input flag, output cpu_in);
endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module io_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage write; contents are don't-care once pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/io_port_responder.sv
// Device-end responder for the CPU I/O bus: GPIO latch, synchronised GPIO
// input, TX FIFO to a sink and RX FIFO from a source. Read data is registered
// (one cycle latency). Optional macro IO_TIMER_EN adds a free-running timer
// at port 0x0005.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  io_port_responder_if.slave        bus,
  output word_t                     gpio_out,
  input  word_t                     gpio_in,
  output word_t                     tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  word_t                     rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready
);
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic  tx_full, tx_empty, tx_pop;
  logic  rx_full, rx_empty, rx_push;
  word_t rx_head;
  logic  wr_status, wr_gpio, wr_tx, wr_rx;
  logic  tx_overflow;
  word_t sync1, sync2;
  word_t cpu_in_q;
  word_t rd_word;

  assign wr_status = bus.flag && (bus.base == P_STATUS);
  assign wr_gpio   = bus.flag && (bus.base == P_GPIO_OUT);
  assign wr_tx     = bus.flag && (bus.base == P_TX);
  assign wr_rx     = bus.flag && (bus.base == P_RX);

  assign tx_valid = !tx_empty && !reset;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full && !reset;
  assign rx_push  = rx_valid && rx_ready;

  assign bus.cpu_in = cpu_in_q;

  io_fifo #(.WIDTH(16), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .push_data(bus.data), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_data)
  );

  io_fifo #(.WIDTH(16), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_data), .pop(wr_rx),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

`ifdef IO_TIMER_EN
  word_t timer;
  logic  wr_timer;
  assign wr_timer = bus.flag && (bus.base == P_TIMER);

  // Free-running counter; a write reloads it and counting resumes from there.
  always_ff @(posedge clk) begin
    if (reset)         timer <= '0;
    else if (wr_timer) timer <= bus.data;
    else               timer <= timer + 16'd1;
  end
`endif

  // Read decode of the currently addressed port.
  always_comb begin
    rd_word = '0;
    case (bus.base)
      P_STATUS: begin
        rd_word[ST_TX_EMPTY]           = tx_empty;
        rd_word[ST_TX_FULL]            = tx_full;
        rd_word[ST_RX_AVAIL]           = !rx_empty;
        rd_word[ST_TX_OVF]             = tx_overflow;
        rd_word[ST_RX_CNT_LO +: 4]     = 4'(rx_count);
        rd_word[ST_TX_CNT_LO +: 4]     = 4'(tx_count);
      end
      P_GPIO_OUT: rd_word = gpio_out;
      P_GPIO_IN:  rd_word = sync2;
      P_TX:       rd_word = 16'(tx_count);
      P_RX:       rd_word = rx_empty ? '0 : rx_head;
`ifdef IO_TIMER_EN
      P_TIMER:    rd_word = timer;
`endif
      default:    rd_word = '0;
    endcase
  end

  // Registered read data, GPIO latch, input synchroniser and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_in_q    <= '0;
      gpio_out    <= '0;
      sync1       <= '0;
      sync2       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      cpu_in_q <= rd_word;
      sync1    <= gpio_in;
      sync2    <= sync1;
      if (wr_gpio) gpio_out <= bus.data;
      // Set wins over a same-cycle clear.
      if (wr_tx && tx_full && !tx_pop)   tx_overflow <= 1'b1;
      else if (wr_status && bus.data[0]) tx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: bus reads are scored against
// expected words queued at issue time; TX words are queued when pushed and
// checked as the sink consumes them.
module tb_io_port_responder;
  import io_port_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  word_t gpio_out, gpio_in, tx_data, rx_data;
  logic  tx_valid, tx_ready, rx_valid, rx_ready;

  io_port_responder_if bus_if ();

  io_port_responder #(.TX_DEPTH(8), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .gpio_out(gpio_out), .gpio_in(gpio_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t rd_exp_q[$];
  word_t tx_exp_q[$];
  word_t rx_model_q[$];
  int    tx_model_cnt = 0;

  task automatic check_eq(string tag, word_t got, word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(word_t a, word_t d);
    bus_if.base = a;
    bus_if.data = d;
    bus_if.flag = 1'b1;
    cyc();
    bus_if.flag = 1'b0;
  endtask

  task automatic rd(string tag, word_t a, word_t e);
    bus_if.base = a;
    rd_exp_q.push_back(e);
    cyc();
    check_eq(tag, bus_if.cpu_in, rd_exp_q.pop_front());
  endtask

  // TX sink scoreboard: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      check_eq("tx_pending", 16'(tx_exp_q.size() != 0), 16'h0001);
      if (tx_exp_q.size() != 0) check_eq("tx_data", tx_data, tx_exp_q.pop_front());
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    bus_if.base = '0; bus_if.data = '0; bus_if.flag = 1'b0;
    gpio_in = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) cyc();
    check_eq("rst_cpu_in", bus_if.cpu_in, 16'h0000);
    check_eq("rst_gpio_out", gpio_out, 16'h0000);
    check_eq("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check_eq("rst_rx_ready", 16'(rx_ready), 16'h0000);
    reset = 1'b0;
    #1;
    check_eq("rx_ready_after_rst", 16'(rx_ready), 16'h0001);

    // GPIO out, status after reset, unmapped and read-only ports
    wr(16'h0001, 16'hA5A5);
    check_eq("gpio_out", gpio_out, 16'hA5A5);
    rd("gpio_out_rd", 16'h0001, 16'hA5A5);
    rd("status_idle", 16'h0000, 16'h0001);
    wr(16'h0007, 16'hFFFF);
    rd("unmapped_rd", 16'h0007, 16'h0000);
    wr(16'h0002, 16'h1234);
    rd("gpio_in_ro", 16'h0002, 16'h0000);

    // TX overflow: 9 pushes into an 8-deep FIFO with the sink stalled
    for (int i = 0; i < 9; i++) begin
      wr(16'h0003, 16'h0010 + 16'(i));
      if (tx_model_cnt < 8) begin
        tx_exp_q.push_back(16'h0010 + 16'(i));
        tx_model_cnt++;
      end
      if (i == 0) check_eq("tx_valid_first", 16'(tx_valid), 16'h0001);
    end
    rd("tx_count_full", 16'h0003, 16'h0008);
    check_eq("tx_head_stall", tx_data, 16'h0010);
    rd("status_ovf", 16'h0000, 16'h080A);
    wr(16'h0000, 16'h0001);
    rd("status_ovf_clr", 16'h0000, 16'h0802);

    // Push into a full FIFO while the sink pops in the same cycle
    bus_if.base = 16'h0003;
    bus_if.data = 16'h00FF;
    bus_if.flag = 1'b1;
    tx_ready    = 1'b1;
    tx_exp_q.push_back(16'h00FF);
    cyc();
    bus_if.flag = 1'b0;
    n = 0;
    while (tx_valid && n < 40) begin
      cyc();
      n++;
    end
    check_eq("tx_drained", 16'(tx_valid), 16'h0000);
    check_eq("tx_q_empty", 16'(tx_exp_q.size()), 16'h0000);
    tx_ready = 1'b0;
    tx_model_cnt = 0;
    rd("status_no_ovf", 16'h0000, 16'h0001);

    // RX flow: 5 offered words, 4-deep FIFO
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 16'h1001 + 16'(i);
      if (i < 4) begin
        check_eq("rx_ready_open", 16'(rx_ready), 16'h0001);
        rx_model_q.push_back(rx_data);
      end else begin
        check_eq("rx_ready_full", 16'(rx_ready), 16'h0000);
      end
      cyc();
    end
    rx_valid = 1'b0;
    rd("status_rx4", 16'h0000, 16'h0045);
    rd("rx_head0", 16'h0004, rx_model_q[0]);
    wr(16'h0004, 16'h0000);
    void'(rx_model_q.pop_front());
    rd("rx_head1", 16'h0004, rx_model_q[0]);
    repeat (3) begin
      wr(16'h0004, 16'h0000);
      void'(rx_model_q.pop_front());
    end
    rd("rx_empty_rd", 16'h0004, 16'h0000);
    wr(16'h0004, 16'h0000);
    rd("status_rx_empty", 16'h0000, 16'h0001);

    // Simultaneous accept and pop keeps the count
    rx_valid = 1'b1;
    rx_data  = 16'h2222;
    cyc();
    rx_data  = 16'h3333;
    wr(16'h0004, 16'h0000);
    rx_valid = 1'b0;
    rd("status_rx1", 16'h0000, 16'h0015);
    rd("rx_head_swap", 16'h0004, 16'h3333);

    // GPIO input synchroniser latency
    rd("gpio_in_old", 16'h0002, 16'h0000);
    gpio_in = 16'h3C3C;
    rd("gpio_in_e1", 16'h0002, 16'h0000);
    rd("gpio_in_e2", 16'h0002, 16'h0000);
    rd("gpio_in_e3", 16'h0002, 16'h3C3C);

    // Timer port
    wr(16'h0005, 16'hFFFE);
`ifdef IO_TIMER_EN
    rd("timer0", 16'h0005, 16'hFFFE);
    rd("timer1", 16'h0005, 16'hFFFF);
    rd("timer2", 16'h0005, 16'h0000);
    rd("timer3", 16'h0005, 16'h0001);
`else
    rd("timer_off0", 16'h0005, 16'h0000);
    rd("timer_off1", 16'h0005, 16'h0000);
`endif

    // Reset mid-operation abandons queued TX words
    wr(16'h0003, 16'h0055);
    wr(16'h0003, 16'h0066);
    check_eq("tx_valid_pre_rst", 16'(tx_valid), 16'h0001);
    reset = 1'b1;
    cyc();
    tx_exp_q.delete();
    check_eq("mid_rst_tx_valid", 16'(tx_valid), 16'h0000);
    check_eq("mid_rst_rx_ready", 16'(rx_ready), 16'h0000);
    check_eq("mid_rst_gpio", gpio_out, 16'h0000);
    reset = 1'b0;
    rd("status_post_rst", 16'h0000, 16'h0001);
    tx_ready = 1'b1;
    repeat (3) cyc();
    check_eq("tx_idle_post_rst", 16'(tx_valid), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Responder at the device end of the CPU I/O bus.
- Decodes the CPU's port address (`base`, driven from bx), write data (`data`, driven from dx) and write strobe (`flag`, pulsed by OUT).
- Returns read data on `cpu_in`, which feeds the CPU's `in` input consumed by IN.
- Contains a GPIO output latch, a synchronised GPIO input, a TX FIFO toward an external sink and an RX FIFO from an external source.

Parameters:
TX_DEPTH, 8, TX FIFO entries; power of two, 2..8
RX_DEPTH, 4, RX FIFO entries; power of two, 2..8

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
base  input  16  port address from CPU
data  input  16  write data from CPU
flag  input  1  write strobe; every cycle high is one write
cpu_in  output  16  registered read data to CPU `in`
gpio_out  output  16  GPIO output latch
gpio_in  input  16  asynchronous GPIO inputs
tx_data  output  16  TX FIFO head word
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  sink accepts tx_data
rx_data  input  16  incoming word
rx_valid  input  1  source offers rx_data
rx_ready  output  1  RX FIFO not full

Behaviour:
- Reset: clk and reset as named above. Reset is synchronous, active-high.
  - While reset is high: FIFOs empty, gpio_out=0, cpu_in=0, tx_valid=0, rx_ready=0, tx_overflow=0, sync flops=0.
  - rx_ready rises on the first cycle after reset drops.
- Port map:
  - 0x0000 STATUS.
    - Read: [0] tx_empty, [1] tx_full, [2] rx_avail, [3] tx_overflow, [7:4] rx_count, [11:8] tx_count, others 0.
    - Write with data[0]=1 clears tx_overflow.
  - 0x0001 GPIO_OUT. Write loads gpio_out; read returns gpio_out.
  - 0x0002 GPIO_IN. Read only; returns the 2-flop synchronised gpio_in. Writes are ignored.
  - 0x0003 TX.
    - Write pushes data.
    - Read returns tx_count zero-extended.
  - 0x0004 RX.
    - Read returns the RX head word, or 0 if empty.
    - A write of any value pops the head.
  - Any other address: writes ignored, reads 0.
- Read path: cpu_in is registered. It reflects the decode of base and state as sampled at the previous edge, giving 1-cycle latency.
  - The CPU always sets bx at least one instruction before IN.
- Write handling: each write is acted on at the edge where flag=1. Back-to-back writes on consecutive cycles are all honoured.
- TX FIFO:
  - A push is accepted if tx_count<TX_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and tx_overflow is set. tx_overflow is sticky; set has priority over a same-cycle clear.
  - A pop occurs on tx_valid&&tx_ready.
  - A push into an empty FIFO makes tx_valid high the next cycle.
  - tx_data is the head word; it is stable while tx_valid&&!tx_ready.
- RX FIFO:
  - rx_ready = !rx_full.
  - A word is accepted on rx_valid&&rx_ready.
  - A pop on empty is ignored.
  - A simultaneous accept and pop keeps the count unchanged.
  - The popped word leaves cpu_in on the following registered update.
- Pointers: read and write pointers wrap modulo depth. Count width is clog2(depth)+1.
- Reset mid-operation: FIFO contents are discarded, pointers are zeroed, and any in-flight tx handshake is abandoned (tx_valid=0).

Optional Feature:
IO_TIMER_EN
- Defined: port 0x0005 is TIMER, a free-running 16-bit counter incrementing every cycle and wrapping 0xFFFF→0x0000.
  - Read returns the counter value.
  - A write loads data, and the counter increments from that value on the next cycle.
  - Reset value is 0.
- Undefined: no counter logic; 0x0005 behaves as an unmapped port.

Decomposition:
- Shared package io_port_pkg:
  - port address localparams (P_STATUS, P_GPIO_OUT, P_GPIO_IN, P_TX, P_RX, P_TIMER);
  - STATUS bit indices;
  - 16-bit word typedef.
- Sub-module io_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push/pop/full/empty/count/head.
  - Instantiated for both TX and RX.

Test Plan:
- Reset then writes: after reset, write 0x0001←0xA5A5, then read base=0x0001 → cpu_in=0xA5A5 one cycle later; gpio_out=0xA5A5.
- TX overflow: with tx_ready=0, push 9 words 0x0010..0x0018 to 0x0003 → tx_count=8, STATUS[3]=1, and the 9th word is dropped. Then raise tx_ready → tx_data sequence is 0x0010..0x0017 and tx_valid falls.
- Full FIFO push with pop: with the TX FIFO full and tx_ready=1 in the same cycle as a push of 0x00FF → push accepted, tx_overflow unchanged, 0x00FF is eventually emitted.
- RX flow: drive 5 words 0x1001..0x1005 with rx_valid=1 → rx_ready drops after 4, STATUS rx_count=4. Read 0x0004=0x1001, write 0x0004, read again → 0x1002.
- GPIO_IN sync: change gpio_in to 0x3C3C → the read of 0x0002 shows the new value no earlier than 3 edges after the change.
- Timer (IO_TIMER_EN defined): write 0x0005←0xFFFE, then read on consecutive cycles → values wrap through 0x0000. With the macro undefined → reads 0.
